// File: rtl/rx_pkg.sv
// rx_pkg: shared widths, FIFO entry layout and head-FSM states for the frame store
package rx_pkg;
    localparam int ID_W = 2;
    localparam int PAYLOAD_W = 128;
    localparam logic [ID_W-1:0] BCAST_ID = 2'b11;

    typedef struct packed {
        logic [ID_W-1:0]      src_id;
        logic [PAYLOAD_W-1:0] payload;
    } rx_entry_t;

    typedef enum logic {ST_EMPTY, ST_SHOW} head_state_t;
endpackage

// File: rtl/rx_frame_fifo.sv
// rx_frame_fifo: frame storage with pointers, occupancy and same-cycle push/pop arbitration
module rx_frame_fifo
    import rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  rx_entry_t              din,
    output logic                   push_ok,
    output logic                   pop_ok,
    output rx_entry_t              next_head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    rx_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count_nx;

    // A pop frees the slot the push lands in, so a full FIFO still accepts
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign count_nx  = count + CW'(push_ok) - CW'(pop_ok);
    assign next_head = mem[rd_ptr + 1'b1];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            rd_ptr <= rd_ptr + AW'(pop_ok);
            wr_ptr <= wr_ptr + AW'(push_ok);
            count  <= count_nx;
            full   <= count_nx == CW'(DEPTH);
            empty  <= count_nx == '0;
        end
    end
endmodule

// File: rtl/rx_frame_store.sv
// rx_frame_store: classifies received frames, queues accepted ones and keeps saturating stats
// Define RX_STORE_BROADCAST_EN to accept dest_id==BCAST_ID on every node.
module rx_frame_store
    import rx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ID_W-1:0]        my_id,
    input  logic                   frame_valid,
    input  logic                   crc_error,
    input  logic [ID_W-1:0]        dest_id,
    input  logic [ID_W-1:0]        src_id,
    input  logic [PAYLOAD_W-1:0]   payload,
    input  logic                   pop,
    output logic                   out_valid,
    output logic [ID_W-1:0]        out_src_id,
    output logic [PAYLOAD_W-1:0]   out_payload,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic [CNT_W-1:0]       crc_err_cnt,
    output logic [CNT_W-1:0]       mismatch_cnt,
    output logic [CNT_W-1:0]       drop_cnt
);
    logic hit, crc_hit, miss_hit, accept, push_ok, pop_ok;
    rx_entry_t din, next_head, head;
    head_state_t state;

`ifdef RX_STORE_BROADCAST_EN
    assign hit = dest_id == my_id || dest_id == BCAST_ID;
`else
    assign hit = dest_id == my_id;
`endif

    assign crc_hit  = frame_valid && crc_error;
    assign miss_hit = frame_valid && !crc_error && !hit;
    assign accept   = frame_valid && !crc_error && hit;
    assign din      = '{src_id: src_id, payload: payload};

    rx_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .pop       (pop),
        .din       (din),
        .push_ok   (push_ok),
        .pop_ok    (pop_ok),
        .next_head (next_head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_err_cnt  <= '0;
            mismatch_cnt <= '0;
            drop_cnt     <= '0;
        end else begin
            if (crc_hit && crc_err_cnt != '1)
                crc_err_cnt <= crc_err_cnt + 1'b1;
            if (miss_hit && mismatch_cnt != '1)
                mismatch_cnt <= mismatch_cnt + 1'b1;
            if (accept && !push_ok && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // With a single entry left the next head is the word being pushed, not yet in storage
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            head      <= '0;
        end else if (state == ST_EMPTY) begin
            if (push_ok) begin
                state     <= ST_SHOW;
                out_valid <= 1'b1;
                head      <= din;
            end
        end else if (pop_ok) begin
            if (count == 1 && !push_ok) begin
                state     <= ST_EMPTY;
                out_valid <= 1'b0;
            end else begin
                head <= count > 1 ? next_head : din;
            end
        end
    end

    assign out_src_id  = head.src_id;
    assign out_payload = head.payload;
endmodule

// File: tb/tb_rx_frame_store.sv
// tb_rx_frame_store: directed and random stimulus against a queue-based reference model
module tb_rx_frame_store;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int SAT = (1 << CNT_W) - 1;

    logic clk = 0, rst = 1;
    logic [1:0] my_id = 0, dest_id = 0, src_id = 0;
    logic frame_valid = 0, crc_error = 0, pop = 0;
    logic [127:0] payload = '0;
    logic out_valid, full, empty;
    logic [1:0] out_src_id;
    logic [127:0] out_payload;
    logic [2:0] count;
    logic [CNT_W-1:0] crc_err_cnt, mismatch_cnt, drop_cnt;

    rx_frame_store #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .my_id(my_id), .frame_valid(frame_valid),
        .crc_error(crc_error), .dest_id(dest_id), .src_id(src_id), .payload(payload),
        .pop(pop), .out_valid(out_valid), .out_src_id(out_src_id), .out_payload(out_payload),
        .count(count), .full(full), .empty(empty), .crc_err_cnt(crc_err_cnt),
        .mismatch_cnt(mismatch_cnt), .drop_cnt(drop_cnt)
    );

    always #10 clk = ~clk;

    int n_pass = 0, n_total = 0;
    logic [129:0] q[$];
    logic [129:0] last_head = '0;
    int m_crc = 0, m_miss = 0, m_drop = 0;

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: a queue of accepted frames, popped before pushed within a cycle
    task automatic model_step();
        bit hit, popped;
        if (rst) begin
            q.delete();
            last_head = '0;
            m_crc = 0; m_miss = 0; m_drop = 0;
            return;
        end
        popped = 0;
        if (pop && q.size() > 0) begin
            void'(q.pop_front());
            popped = 1;
        end
        hit = dest_id == my_id;
`ifdef RX_STORE_BROADCAST_EN
        hit = hit || dest_id == 2'b11;
`endif
        if (frame_valid) begin
            if (crc_error) m_crc = m_crc < SAT ? m_crc + 1 : SAT;
            else if (!hit) m_miss = m_miss < SAT ? m_miss + 1 : SAT;
            else if (q.size() < DEPTH) q.push_back({src_id, payload});
            else m_drop = m_drop < SAT ? m_drop + 1 : SAT;
        end
        if (q.size() > 0) last_head = q[0];
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, out_valid, q.size() > 0);
        chk({tag, ".count"}, count, q.size());
        chk({tag, ".full"}, full, q.size() == DEPTH);
        chk({tag, ".empty"}, empty, q.size() == 0);
        chk({tag, ".head"}, {out_src_id, out_payload}, last_head);
        chk({tag, ".crc_cnt"}, crc_err_cnt, m_crc);
        chk({tag, ".miss_cnt"}, mismatch_cnt, m_miss);
        chk({tag, ".drop_cnt"}, drop_cnt, m_drop);
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
        frame_valid = 0;
        pop = 0;
    endtask

    task automatic frame(input string tag, input bit crc, input logic [1:0] d, input logic [1:0] s,
                         input logic [127:0] pl, input bit p);
        frame_valid = 1; crc_error = crc; dest_id = d; src_id = s; payload = pl; pop = p;
        cyc(tag);
    endtask

    task automatic do_pop(input string tag);
        pop = 1;
        cyc(tag);
    endtask

    initial begin
        cyc("reset");
        cyc("reset2");
        rst = 0;
        my_id = 1;
        frame("first", 0, 1, 2, 128'h00A5, 0);
        chk("first.lsb", out_payload[7:0], 8'hA5);
        chk("first.src", out_src_id, 2'd2);
        frame("bcast_dest", 0, 3, 1, 128'h1234, 0);
        frame("crc", 1, 1, 0, 128'h5555, 0);
        chk("crc.cnt1", crc_err_cnt, 8'd1);
        while (q.size() > 0) do_pop("drain");
        for (int i = 1; i <= 5; i++) frame("fill", 0, 1, 2'(i), 128'(i), 0);
        chk("fill.full", full, 1'b1);
        chk("fill.drop", drop_cnt, 8'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("order", out_payload, 128'(i));
            do_pop("pop4");
        end
        chk("pop4.valid", out_valid, 1'b0);
        do_pop("pop_empty");
        frame("empty_pushpop", 0, 1, 3, 128'h77, 1);
        for (int i = 0; i < 3; i++) frame("refill", 0, 1, 0, 128'(16 + i), 0);
        frame("full_pushpop", 0, 1, 1, 128'hBEEF, 1);
        chk("full_pushpop.count", count, 3'd4);
        for (int i = 0; i < 4; i++) do_pop("drain2");
        chk("last_read", out_payload, 128'hBEEF);
        for (int i = 0; i < 600; i++) begin
            my_id = 2'($urandom);
            frame_valid = ($urandom_range(0, 3) != 0);
            crc_error = ($urandom_range(0, 4) == 0);
            dest_id = 2'($urandom);
            src_id = 2'($urandom);
            payload = {$urandom, $urandom, $urandom, $urandom};
            pop = ($urandom_range(0, 2) == 0);
            cyc("random");
        end
        for (int i = 0; i < 300; i++) frame("crc_sat", 1, 2'($urandom), 0, 128'(i), 0);
        chk("crc_sat.val", crc_err_cnt, 8'd255);
        frame("pre_rst", 0, my_id, 1, 128'h99, 0);
        rst = 1;
        frame("mid_rst", 0, my_id, 2, 128'hAA, 1);
        chk("mid_rst.payload", out_payload, 128'h0);
        rst = 0;
        cyc("post_rst");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/rx_frame_store.md
# rx_frame_store

Downstream consumer of the receiver's frame outputs. Classifies every completed frame (CRC error, destination mismatch, accepted), queues accepted frames in a small FIFO with first-word-fall-through head presentation, and keeps saturating statistics counters. Sits between the receiver and the board display/LED logic so the user can step through frames that arrived faster than they could be read.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- CNT_W, 8: width of each statistics counter.

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- rst  in  1  synchronous, active-high reset
- my_id  in  2  this node's ID (board switches); sampled every cycle
- frame_valid  in  1  one-cycle pulse marking a completed frame
- crc_error  in  1  qualifies the frame; sampled only when frame_valid=1
- dest_id  in  2  frame destination; sampled only when frame_valid=1
- src_id  in  2  frame source; sampled only when frame_valid=1
- payload  in  128  frame payload; sampled only when frame_valid=1
- pop  in  1  one-cycle request to discard the head entry (already debounced/edge-detected)
- out_valid  out  1  head entry present
- out_src_id  out  2  head entry source ID
- out_payload  out  128  head entry payload
- count  out  $clog2(DEPTH)+1  entries held
- full  out  1  count==DEPTH
- empty  out  1  count==0
- crc_err_cnt  out  CNT_W  frames with crc_error=1
- mismatch_cnt  out  CNT_W  CRC-clean frames not addressed to my_id
- drop_cnt  out  CNT_W  accepted frames lost because FIFO was full

## Operation
- Classification at a frame_valid cycle, in priority order:
  - crc_error=1: discard; crc_err_cnt+1. Destination is not checked.
  - dest_id!=my_id (and not broadcast, see Configuration): discard; mismatch_cnt+1.
  - Otherwise: accepted; push {src_id, payload}.
- Push while full and no pop in the same cycle: frame dropped, drop_cnt+1, FIFO contents unchanged (oldest data kept).
- Push and pop in the same cycle while full: both succeed, count unchanged, drop_cnt unchanged.
- Push and pop in the same cycle while empty: push succeeds, pop ignored.
- Pop while empty: ignored, no state change.
- All counters saturate at 2^CNT_W-1 and never wrap.
- Head FSM with two states:
  - EMPTY: out_valid=0. Any push moves to SHOW.
  - SHOW: out_valid=1. A pop with count==1 and no simultaneous push returns to EMPTY. All other cases stay in SHOW.
- out_src_id/out_payload always reflect the entry at the read pointer. They hold their last value while out_valid=0.
- Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. count tracks occupancy separately.

## Timing
- Reset (rst=1 at a clk edge): count=0, empty=1, full=0, out_valid=0, out_src_id=0, out_payload=0, all counters=0, pointers=0, FSM=EMPTY.
- Reset has priority over everything: a frame_valid or pop in the reset cycle is lost.
- Frame at edge T (frame_valid=1):
  - count, counters and full/empty update at T+1.
  - If the FIFO was empty, out_valid=1 with the new data at T+1.
- Pop at edge T: the next head entry (or out_valid=0) is visible at T+1.
- Throughput is one frame per cycle. Back-to-back frame_valid pulses are supported.
- All outputs are registered. No combinational path from any input to any output.

## Configuration
- RX_STORE_BROADCAST_EN
  - Defined: dest_id==2'b11 is accepted by every node regardless of my_id, and is not counted as a mismatch.
  - Undefined: 2'b11 is an ordinary ID, matched only when my_id==2'b11.

## Structure
- Shared package rx_pkg holds:
  - ID_W=2, PAYLOAD_W=128, BCAST_ID=2'b11.
  - Typedef rx_entry_t = {src_id, payload}.
  - Head-FSM state enum.
- One sub-module, rx_frame_fifo: storage array, pointers, count, full/empty, same-cycle push/pop rules.
- Classification, statistics counters and the head FSM live in rx_frame_store.

## Test plan
- Reset, then my_id=1; frame dest=1, src=2, payload=0x..00A5, crc_error=0 -> next cycle out_valid=1, out_src_id=2, out_payload[7:0]=0xA5, count=1.
- Frame dest=3 with my_id=1 -> mismatch_cnt=1, count unchanged. With RX_STORE_BROADCAST_EN defined -> accepted, count+1, mismatch_cnt=0.
- Frame with crc_error=1 and dest=1 -> crc_err_cnt=1, mismatch_cnt=0, count unchanged.
- Five back-to-back accepted frames, payloads 1..5, DEPTH=4 -> full=1, drop_cnt=1. Four pops -> out_payload 1,2,3,4 in order, then out_valid=0, empty=1.
- FIFO full, push and pop in the same cycle -> count stays 4, drop_cnt unchanged, new payload is read last.
- 300 CRC-error frames -> crc_err_cnt saturates at 255. Assert rst mid-stream -> all outputs return to reset values the next cycle.
